// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } tx_state_t;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    localparam logic [31:0] DATA_ADDR_DEFAULT   = 32'h4000_0010;
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h4000_0014;

    // STATUS has a 4-bit count field; deeper FIFOs report 15 when fuller than that.
    function automatic logic [3:0] sat_count(input int unsigned c);
        return (c > 15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MEM-stage IO bus as seen by the UART: store strobe, address, data and combinational read-back.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int unsigned AW = $clog2(Depth);

    logic [7:0]  mem_q [Depth];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop on the same edge frees the slot being written, so a full push is still accepted.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA stores feed a TX FIFO drained by a baud-rate FSM.
// Define UART_TX_PARITY_EN for 8E1 framing; default is 8N1.
module mmio_uart_tx import uart_pkg::*; #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] ADDR_DATA   = DATA_ADDR_DEFAULT,
    parameter logic [31:0] ADDR_STATUS = STATUS_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            tx,
    output logic            busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned NW           = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          push_req, clr_req, ovf_evt, cnt_last;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [NW-1:0] fifo_count;

    assign push_req = bus.we && (bus.addr == ADDR_DATA);
    assign clr_req  = bus.we && (bus.addr == ADDR_STATUS) && bus.wdata[ST_OVF];
    assign ovf_evt  = push_req && fifo_full && !fifo_pop;
    assign cnt_last = (cnt_q == CW'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A drop on the same edge as a W1C keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_req) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

    // tx_d is the line level for the state being entered, so tx is a clean register output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        if (state_q != StIdle) cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    cnt_d    = '0;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                end
            end
            StStart: begin
                if (cnt_last) begin
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (cnt_last) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^shift_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (cnt_last) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_last) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = StStart;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) || !fifo_empty;

    always_comb begin
        bus.rdata = '0;
        if (bus.addr == ADDR_STATUS) begin
            bus.rdata[ST_BUSY]           = busy;
            bus.rdata[ST_FULL]           = fifo_full;
            bus.rdata[ST_EMPTY]          = fifo_empty;
            bus.rdata[ST_OVF]            = ovf_q;
            bus.rdata[ST_CNT_LSB +: 4]   = sat_count(32'(fifo_count));
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at 16 clocks per bit.
// Honours UART_TX_PARITY_EN the same way as the RTL.
module tb_mmio_uart_tx;

    localparam int unsigned CPB     = 16;
    localparam logic [31:0] A_DATA  = 32'h4000_0010;
    localparam logic [31:0] A_STAT  = 32'h4000_0014;
    localparam logic [31:0] A_OTHER = 32'h4000_0018;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS     = 11;
    localparam int unsigned FRAME_LEN = 176;
`else
    localparam int unsigned NBITS     = 10;
    localparam int unsigned FRAME_LEN = 160;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, busy;
    int   checks = 0;
    int   errors = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_HZ      (16),
        .BAUD        (1),
        .FIFO_DEPTH  (8),
        .ADDR_DATA   (A_DATA),
        .ADDR_STATUS (A_STAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we    = 1'b0;
        bus.addr  = A_STAT;
        bus.wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
        bus.addr = A_STAT;
    endtask

    // Line level expected in bit slot i of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Call at the negedge right after the push edge, with nothing else queued.
    task automatic check_frame(input logic [7:0] b, input string tag, output int len,
                               output logic par);
        int bad;
        bad = 0;
        len = 0;
        par = 1'bx;
        for (int k = 1; k <= int'(NBITS * CPB) + 4; k++) begin
            @(negedge clk);
            if (busy === 1'b1) len++;
            if (k <= int'(NBITS * CPB)) begin
                if (tx !== exp_bit(b, (k - 1) / int'(CPB))) bad++;
            end else if (tx !== 1'b1) begin
                bad++;
            end
            if (k == 9 * int'(CPB) + 8) par = tx;
        end
        check({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Sample one frame mid-bit; gap is the number of cycles spent waiting for the start bit.
    task automatic rx_byte(input string tag, output logic [7:0] b, output int gap);
        gap = 0;
        b   = '0;
        while (tx !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        check({tag, "_start_seen"}, 32'(gap < 400), 32'd1);
        repeat (CPB / 2) @(negedge clk);
        check({tag, "_start_bit"}, 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        check({tag, "_parity"}, 32'(tx), 32'(^b));
`endif
        repeat (CPB) @(negedge clk);
        check({tag, "_stop_bit"}, 32'(tx), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  exp4 [9];
        logic        par;
        int          gap, len, bad;

        bus.addr  = A_STAT;
        bus.wdata = '0;
        bus.we    = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset state, read decode
        rd(A_STAT, r);
        check("t1_status_in_reset", r, 32'h4);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_tx", 32'(tx), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        rd(A_STAT, r);
        check("t1_status", r, 32'h0000_0004);
        rd(A_DATA, r);
        check("t1_data_reads_zero", r, 32'h0);
        rd(32'h4000_0000, r);
        check("t1_unmapped_zero", r, 32'h0);
        store(A_OTHER, 32'hA5);
        @(negedge clk);
        rd(A_STAT, r);
        check("t1_other_write_ignored", r, 32'h4);
        check("t1_other_tx", 32'(tx), 32'd1);

        // 2: single 0xA5 frame
        store(A_DATA, 32'hA5);
        check("t2_tx_push_edge", 32'(tx), 32'd1);
        check("t2_busy_push_edge", 32'(busy), 32'd1);
        check_frame(8'hA5, "t2", len, par);
        check("t2_frame_len", 32'(len), 32'(FRAME_LEN));

        // 3: back-to-back frames
        store(A_DATA, 32'h11);
        store(A_DATA, 32'h22);
        store(A_DATA, 32'h33);
        rd(A_STAT, r);
        check("t3_count", 32'(r[7:4]), 32'd2);
        check("t3_status", r, 32'h21);
        rx_byte("t3_f1", b, gap);
        check("t3_byte1", 32'(b), 32'h11);
        rx_byte("t3_f2", b, gap);
        check("t3_byte2", 32'(b), 32'h22);
        // First frame was picked up one cycle into its start bit, hence 7 here.
        check("t3_gap2", 32'(gap), 32'd7);
        rx_byte("t3_f3", b, gap);
        check("t3_byte3", 32'(b), 32'h33);
        check("t3_gap3", 32'(gap), 32'd8);
        repeat (10) @(negedge clk);
        check("t3_idle_busy", 32'(busy), 32'd0);

        // 4: overflow, W1C, push+pop while full
        store(A_DATA, 32'h40);
        for (int i = 1; i <= 9; i++) store(A_DATA, 32'h40 + 32'(i));
        rd(A_STAT, r);
        check("t4_status_ovf", r, 32'h8B);
        store(A_STAT, 32'h8);
        rd(A_STAT, r);
        check("t4_status_cleared", r, 32'h83);
        repeat (150) @(negedge clk);
        store(A_DATA, 32'h4A);
        rd(A_STAT, r);
        check("t4_full_push_pop", r, 32'h83);
        exp4 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};
        for (int i = 0; i < 9; i++) begin
            rx_byte($sformatf("t4_f%0d", i), b, gap);
            check($sformatf("t4_byte%0d", i), 32'(b), 32'(exp4[i]));
        end
        repeat (10) @(negedge clk);
        check("t4_idle_busy", 32'(busy), 32'd0);
        rd(A_STAT, r);
        check("t4_idle_status", r, 32'h4);

        // 5: reset mid-frame discards the queue
        store(A_DATA, 32'h52);
        store(A_DATA, 32'h01);
        store(A_DATA, 32'h02);
        repeat (68) @(negedge clk);
        check("t5_bit3_low", 32'(tx), 32'd0);
        rd(A_STAT, r);
        check("t5_status_before", r, 32'h21);
        reset = 1'b0;
        @(negedge clk);
        check("t5_tx_after_reset", 32'(tx), 32'd1);
        rd(A_STAT, r);
        check("t5_status_after_reset", r, 32'h4);
        reset = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_quiet_cycles_bad", 32'(bad), 32'd0);

        // 6: 0x07 frame, parity slot (stop level in 8N1)
        store(A_DATA, 32'h07);
        check_frame(8'h07, "t6", len, par);
        check("t6_frame_len", 32'(len), 32'(FRAME_LEN));
        check("t6_bit9_level", 32'(par), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
